// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder and the controller that drives
// rd_req/wr_req: FSM state encodings, operation codes and the wait-counter width.
package mem_resp_pkg;

  localparam int unsigned CNT_W = 4;  // holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// mem_array: synchronous-write, registered-read word array, no reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write word index
//   wdata  in  write data
//   raddr  in  read word index, captured every edge
//   rdata  out registered read data (word at raddr as of the last edge)
module mem_array #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory responder behind the address register. Accepts a read or
// write request in IDLE, waits WAIT_CYCLES edges, performs the access against
// the internal array and answers with a one-cycle ack (addr_err flags an
// out-of-range address alongside ack).
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   addr, din address / write data, latched when a request is accepted
//   rd_req    read request (level, sampled in IDLE)
//   wr_req    write request (level, sampled in IDLE, wins over rd_req)
//   dout      last completed in-range read data
//   busy      high in ACCESS and RESP
//   ack       one-cycle completion pulse
//   addr_err  out-of-range flag, only ever high together with ack
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              ack,
  output logic              addr_err
);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    din_q;
  op_t                  op_q;
  logic                 oor;
  logic                 access;
  logic                 we;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [DATA_W-1:0]    rdata;

  always_comb begin
    oor    = (addr_q[ADDR_W-1:DEPTH_LOG2] != '0);
    access = (state == ST_ACCESS) && (cnt == '0);
    we     = access && (op_q == OP_WR) && !oor;
    // The array read port follows the live address while idle so the word is
    // already registered by the edge after acceptance; nothing else writes the
    // array, so it is still valid when the access edge copies it into dout.
    raddr  = (state == ST_IDLE) ? addr[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];
  end

  mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q[DEPTH_LOG2-1:0]),
    .wdata (din_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          state_n = ST_ACCESS;
          cnt_n   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ST_ACCESS: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      op_q     <= OP_RD;
      dout     <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      // Outputs are registered from the next state so they line up with it.
      busy     <= (state_n != ST_IDLE);
      ack      <= (state_n == ST_RESP);
      addr_err <= (state_n == ST_RESP) && oor;
      if ((state == ST_IDLE) && (state_n == ST_ACCESS)) begin
        addr_q <= addr;
        din_q  <= din;
        op_q   <= wr_req ? OP_WR : OP_RD;
      end
      if (access && (op_q == OP_RD) && !oor) begin
        dout <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: two instances (WAIT_CYCLES=1 and 4) share the
// same stimulus; each one's ack latency, addr_err and dout are checked
// against hand-computed values.
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;

  logic [15:0] dout1, dout4;
  logic        busy1, busy4, ack1, ack4, err1, err4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_resp #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .rd_req(rd_req), .wr_req(wr_req),
    .dout(dout1), .busy(busy1), .ack(ack1), .addr_err(err1)
  );

  mem_resp #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .rd_req(rd_req), .wr_req(wr_req),
    .dout(dout4), .busy(busy4), .ack(ack4), .addr_err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; optionally pulses wr_req to word 4 while both DUTs are in ACCESS.
  task automatic run(input string tag, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic pulse, input logic exp_err);
    int lat1, lat4, n1, n4;
    logic e1, e4;
    lat1 = -1; lat4 = -1; n1 = 0; n4 = 0; e1 = 1'bx; e4 = 1'bx;
    @(negedge clk);
    addr = a; din = d; rd_req = rd; wr_req = wr;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    if (pulse) begin
      addr = 16'h0004; din = 16'hDEAD; wr_req = 1'b1;
    end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        wr_req = 1'b0;
        check({tag, "_busy4"}, 32'(busy4), 32'd1);
      end
      if (ack1) begin n1++; if (lat1 < 0) begin lat1 = i; e1 = err1; end end
      if (ack4) begin n4++; if (lat4 < 0) begin lat4 = i; e4 = err4; end end
    end
    check({tag, "_lat1"}, 32'(lat1), 32'd1);
    check({tag, "_lat4"}, 32'(lat4), 32'd4);
    check({tag, "_acks1"}, 32'(n1), 32'd1);
    check({tag, "_acks4"}, 32'(n4), 32'd1);
    check({tag, "_err1"}, 32'(e1), 32'(exp_err));
    check({tag, "_err4"}, 32'(e4), 32'(exp_err));
    check({tag, "_idle"}, {busy1, busy4, err1, err4}, 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    run(tag, 1'b1, 1'b0, a, 16'h0000, 1'b0, 1'b0);
    check({tag, "_dout1"}, 32'(dout1), 32'(exp));
    check({tag, "_dout4"}, 32'(dout4), 32'(exp));
  endtask

  initial begin
    int nack;
    // 1: reset asserted mid-cycle clears outputs at once
    #3 rst = 1'b1;
    #1;
    check("rst_out1", {dout1, busy1, ack1, err1}, 32'd0);
    check("rst_out4", {dout4, busy4, ack4, err4}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // 2: write then read back
    run("wr10", 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b0);
    rd_check("rd10", 16'h0010, 16'hA5A5);

    // 3: out-of-range read and write
    run("rd100", 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1);
    check("rd100_dout1", 32'(dout1), 32'h0000A5A5);
    check("rd100_dout4", 32'(dout4), 32'h0000A5A5);
    run("wrff", 1'b0, 1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    run("wrffff", 1'b0, 1'b1, 16'hFFFF, 16'h5555, 1'b0, 1'b1);
    rd_check("rdff", 16'h00FF, 16'h0F0F);

    // 4: both requests -> write
    run("coll", 1'b1, 1'b1, 16'h0003, 16'h1234, 1'b0, 1'b0);
    rd_check("rd3", 16'h0003, 16'h1234);

    // 5: request during ACCESS is ignored
    run("wr4", 1'b0, 1'b1, 16'h0004, 16'h4444, 1'b0, 1'b0);
    run("wr6p", 1'b0, 1'b1, 16'h0006, 16'h6666, 1'b1, 1'b0);
    rd_check("rd4", 16'h0004, 16'h4444);
    rd_check("rd6", 16'h0006, 16'h6666);

    // 6: reset during ACCESS aborts the write
    run("wr5", 1'b0, 1'b1, 16'h0005, 16'h1111, 1'b0, 1'b0);
    rd_check("rd5a", 16'h0006, 16'h6666);
    @(negedge clk);
    addr = 16'h0005; din = 16'hBEEF; wr_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("abort_busy", {busy1, busy4}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("abort_out1", {dout1, busy1, ack1, err1}, 32'd0);
    check("abort_out4", {dout4, busy4, ack4, err4}, 32'd0);
    @(negedge clk); rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack1 || ack4) nack++;
    end
    check("abort_noack", 32'(nack), 32'd0);
    rd_check("rd5b", 16'h0005, 16'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
